block_frame_sequencer: RTL and testbench

//  In-order frame allocator and commit sequencer for in-flight EDGE blocks in g_tile.

---
 rtl/block_frame_sequencer_if.sv | 35 +++
 rtl/block_frame_sequencer.sv | 116 +++++++++++
 tb/tb_block_frame_sequencer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/block_frame_sequencer_if.sv
// rtl/block_frame_sequencer_if.sv - fetch/completion/commit handshake bundle for the block frame sequencer
interface block_frame_sequencer_if #(
  parameter int NUM_FRAMES = 8,
  parameter int ADDR_W     = 32
);
  localparam int FRAME_W = $clog2(NUM_FRAMES);

  logic                  alloc_req;
  logic [ADDR_W-1:0]     alloc_addr;
  logic                  alloc_ready;
  logic [FRAME_W-1:0]    alloc_frame;
  logic                  done_valid;
  logic [FRAME_W-1:0]    done_frame;
  logic                  flush_req;
  logic [FRAME_W-1:0]    flush_frame;
  logic                  commit_valid;
  logic [FRAME_W-1:0]    commit_frame;
  logic [ADDR_W-1:0]     commit_addr;
  logic                  commit_ack;
  logic [NUM_FRAMES-1:0] inflight_mask;
  logic [NUM_FRAMES-1:0] flush_mask;
  logic [FRAME_W:0]      occupancy;

  modport master (
    output alloc_req, alloc_addr, done_valid, done_frame, flush_req, flush_frame, commit_ack,
    input  alloc_ready, alloc_frame, commit_valid, commit_frame, commit_addr,
           inflight_mask, flush_mask, occupancy
  );

  modport slave (
    input  alloc_req, alloc_addr, done_valid, done_frame, flush_req, flush_frame, commit_ack,
    output alloc_ready, alloc_frame, commit_valid, commit_frame, commit_addr,
           inflight_mask, flush_mask, occupancy
  );
endinterface

// File: rtl/block_frame_sequencer.sv
// rtl/block_frame_sequencer.sv - in-order block frame allocator, oldest-first commit sequencer and flush squasher
module block_frame_sequencer #(
  parameter int NUM_FRAMES = 8,
  parameter int ADDR_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  block_frame_sequencer_if.slave bus
);
  localparam int FRAME_W = $clog2(NUM_FRAMES);
  localparam int CNT_W   = FRAME_W + 1;

  typedef enum logic {C_IDLE, C_WAIT} cstate_e;

  cstate_e               state_q;
  logic [FRAME_W-1:0]    head_q, tail_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [NUM_FRAMES-1:0] valid_q, valid_d, done_q, done_d;
  logic [NUM_FRAMES-1:0] flush_mask_q, squash_set;
  logic [ADDR_W-1:0]     addr_q [NUM_FRAMES];
  logic                  commit_valid_q;
  logic [FRAME_W-1:0]    commit_frame_q;
  logic [ADDR_W-1:0]     commit_addr_q;

  logic                  alloc_fire, ack_fire, flush_fire, commit_start;
  logic [FRAME_W-1:0]    flush_dist;

  assign bus.alloc_ready = rst_n && (count_q < CNT_W'(NUM_FRAMES)) && !bus.flush_req;
  assign alloc_fire      = bus.alloc_req && bus.alloc_ready;
  assign ack_fire        = (state_q == C_WAIT) && bus.commit_ack;
  // The head being committed cannot be squashed; the R/D tiles are already writing it.
  assign flush_fire      = bus.flush_req && valid_q[bus.flush_frame] &&
                           !((state_q == C_WAIT) && (bus.flush_frame == head_q));
  assign flush_dist      = bus.flush_frame - head_q;
  assign commit_start    = (state_q == C_IDLE) && valid_q[head_q] && done_q[head_q] &&
                           !(bus.flush_req && (bus.flush_frame == head_q));

  always_comb begin
    squash_set = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      squash_set[i] = flush_fire && valid_q[i] &&
                      (FRAME_W'(FRAME_W'(i) - head_q) >= flush_dist);
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    if (bus.done_valid && valid_q[bus.done_frame]) done_d[bus.done_frame] = 1'b1;
    if (alloc_fire) begin
      valid_d[tail_q] = 1'b1;
      done_d[tail_q]  = 1'b0;
    end
    if (ack_fire) begin
      valid_d[head_q] = 1'b0;
      done_d[head_q]  = 1'b0;
    end
    valid_d = valid_d & ~squash_set;
    done_d  = done_d & ~squash_set;
  end

  always_comb begin
    count_d = count_q;
    if (flush_fire)      count_d = {1'b0, flush_dist};
    else if (alloc_fire) count_d = count_q + CNT_W'(1);
    if (ack_fire)        count_d = count_d - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= C_IDLE;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      flush_mask_q   <= '0;
      commit_valid_q <= 1'b0;
      commit_frame_q <= '0;
      commit_addr_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      done_q       <= done_d;
      count_q      <= count_d;
      flush_mask_q <= squash_set;
      if (flush_fire)      tail_q <= bus.flush_frame;
      else if (alloc_fire) tail_q <= tail_q + FRAME_W'(1);
      case (state_q)
        C_IDLE: if (commit_start) begin
          state_q        <= C_WAIT;
          commit_valid_q <= 1'b1;
          commit_frame_q <= head_q;
          commit_addr_q  <= addr_q[head_q];
        end
        C_WAIT: if (bus.commit_ack) begin
          state_q        <= C_IDLE;
          commit_valid_q <= 1'b0;
          head_q         <= head_q + FRAME_W'(1);
        end
        default: state_q <= C_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) addr_q[tail_q] <= bus.alloc_addr;
  end

  assign bus.alloc_frame   = tail_q;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_frame  = commit_frame_q;
  assign bus.commit_addr   = commit_addr_q;
  assign bus.inflight_mask = valid_q;
  assign bus.flush_mask    = flush_mask_q;
  assign bus.occupancy     = count_q;
endmodule

// File: tb/tb_block_frame_sequencer.sv
// tb/tb_block_frame_sequencer.sv - directed self-checking bench for block_frame_sequencer
module tb_block_frame_sequencer;
  localparam int NF = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  block_frame_sequencer_if #(.NUM_FRAMES(NF), .ADDR_W(AW)) bus ();

  block_frame_sequencer #(.NUM_FRAMES(NF), .ADDR_W(AW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alloc_req   = 1'b0;
    bus.alloc_addr  = '0;
    bus.done_valid  = 1'b0;
    bus.done_frame  = '0;
    bus.flush_req   = 1'b0;
    bus.flush_frame = '0;
    bus.commit_ack  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic alloc_n(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      bus.alloc_req  = 1'b1;
      bus.alloc_addr = base + 32'h100 * i;
      step();
    end
    bus.alloc_req = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL reset_alloc_ready: got %0b want 0", bus.alloc_ready); end
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid: got %0b want 0", bus.commit_valid); end
    n_cmp++; if (bus.inflight_mask !== 8'h00) begin n_fail++; $display("FAIL reset_inflight: got %h want 00", bus.inflight_mask); end
    n_cmp++; if (bus.flush_mask !== 8'h00) begin n_fail++; $display("FAIL reset_flush_mask: got %h want 00", bus.flush_mask); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.commit_addr !== 32'h0) begin n_fail++; $display("FAIL reset_commit_addr: got %h want 0", bus.commit_addr); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0b want 1", bus.alloc_ready); end
    n_cmp++; if (bus.alloc_frame !== 3'd0) begin n_fail++; $display("FAIL reset_alloc_frame: got %0d want 0", bus.alloc_frame); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.alloc_req  = 1'b1;
      bus.alloc_addr = 32'h1000 + 32'h100 * i;
      #1;
      n_cmp++; if (bus.alloc_ready !== (i < 8)) begin n_fail++; $display("FAIL fill_ready[%0d]: got %0b want %0b", i, bus.alloc_ready, (i < 8)); end
      if (i < 8) begin
        n_cmp++; if (bus.alloc_frame !== 3'(i)) begin n_fail++; $display("FAIL fill_frame[%0d]: got %0d want %0d", i, bus.alloc_frame, i); end
      end
      step();
    end
    bus.alloc_req = 1'b0;
    n_cmp++; if (bus.inflight_mask !== 8'hFF) begin n_fail++; $display("FAIL fill_inflight: got %h want ff", bus.inflight_mask); end
    n_cmp++; if (bus.occupancy !== 4'd8) begin n_fail++; $display("FAIL fill_occupancy: got %0d want 8", bus.occupancy); end
    n_cmp++; if (bus.alloc_frame !== 3'd0) begin n_fail++; $display("FAIL fill_tail_wrap: got %0d want 0", bus.alloc_frame); end
  endtask

  task automatic test_inorder_commit();
    int waited;
    do_reset();
    alloc_n(3, 32'h1000);
    for (int f = 2; f >= 0; f--) begin
      bus.done_valid = 1'b1;
      bus.done_frame = 3'(f);
      step();
    end
    bus.done_valid = 1'b0;
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_early_commit: got %0b want 0", bus.commit_valid); end
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (bus.commit_valid !== 1'b1 && waited < 8) begin step(); waited++; end
      n_cmp++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL order_timeout[%0d]: got commit_valid %0b want 1", k, bus.commit_valid); end
      n_cmp++; if (bus.commit_frame !== 3'(k)) begin n_fail++; $display("FAIL order_frame[%0d]: got %0d want %0d", k, bus.commit_frame, k); end
      n_cmp++; if (bus.commit_addr !== 32'h1000 + 32'h100 * k) begin n_fail++; $display("FAIL order_addr[%0d]: got %h want %h", k, bus.commit_addr, 32'h1000 + 32'h100 * k); end
      step();
      step();
      n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_frame !== 3'(k) || bus.commit_addr !== 32'h1000 + 32'h100 * k) begin
        n_fail++; $display("FAIL order_stable[%0d]: got v=%0b f=%0d a=%h want v=1 f=%0d a=%h", k, bus.commit_valid, bus.commit_frame, bus.commit_addr, k, 32'h1000 + 32'h100 * k);
      end
      bus.commit_ack = 1'b1;
      step();
      bus.commit_ack = 1'b0;
      n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_bubble[%0d]: got %0b want 0", k, bus.commit_valid); end
    end
    n_cmp++; if (bus.occupancy !== 4'd0 || bus.inflight_mask !== 8'h00) begin n_fail++; $display("FAIL order_drained: got occ=%0d mask=%h want occ=0 mask=00", bus.occupancy, bus.inflight_mask); end
  endtask

  task automatic test_flush();
    do_reset();
    alloc_n(6, 32'h3000);
    bus.flush_req   = 1'b1;
    bus.flush_frame = 3'd3;
    bus.alloc_req   = 1'b1;
    bus.alloc_addr  = 32'hDEAD;
    #1;
    n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_alloc: got %0b want 0", bus.alloc_ready); end
    step();
    idle_inputs();
    n_cmp++; if (bus.flush_mask !== 8'h38) begin n_fail++; $display("FAIL flush_mask: got %h want 38", bus.flush_mask); end
    n_cmp++; if (bus.inflight_mask !== 8'h07) begin n_fail++; $display("FAIL flush_inflight: got %h want 07", bus.inflight_mask); end
    n_cmp++; if (bus.occupancy !== 4'd3) begin n_fail++; $display("FAIL flush_occupancy: got %0d want 3", bus.occupancy); end
    n_cmp++; if (bus.alloc_frame !== 3'd3) begin n_fail++; $display("FAIL flush_tail: got %0d want 3", bus.alloc_frame); end
    step();
    n_cmp++; if (bus.flush_mask !== 8'h00) begin n_fail++; $display("FAIL flush_pulse_len: got %h want 00", bus.flush_mask); end
    alloc_n(1, 32'h4000);
    n_cmp++; if (bus.inflight_mask !== 8'h0F) begin n_fail++; $display("FAIL flush_realloc: got %h want 0f", bus.inflight_mask); end
    bus.flush_req   = 1'b1;
    bus.flush_frame = 3'd6;
    step();
    idle_inputs();
    n_cmp++; if (bus.flush_mask !== 8'h00 || bus.inflight_mask !== 8'h0F) begin n_fail++; $display("FAIL flush_invalid_target: got mask=%h inflight=%h want 00/0f", bus.flush_mask, bus.inflight_mask); end
  endtask

  task automatic test_back_to_back();
    int allocs = 0;
    int commits = 0;
    int cyc = 0;
    bit have_prev = 1'b0;
    logic [2:0] prev_frame = '0;
    do_reset();
    while (commits < 10 && cyc < 400) begin
      idle_inputs();
      #1;
      if (have_prev) begin
        bus.done_valid = 1'b1;
        bus.done_frame = prev_frame;
      end
      have_prev = 1'b0;
      if (allocs < 10 && bus.alloc_ready) begin
        n_cmp++; if (bus.alloc_frame !== 3'(allocs % 8)) begin n_fail++; $display("FAIL b2b_frame[%0d]: got %0d want %0d", allocs, bus.alloc_frame, allocs % 8); end
        bus.alloc_req  = 1'b1;
        bus.alloc_addr = 32'h2000 + 32'h10 * allocs;
        prev_frame     = bus.alloc_frame;
        have_prev      = 1'b1;
        allocs++;
      end
      if (bus.commit_valid) begin
        n_cmp++; if (bus.commit_frame !== 3'(commits % 8) || bus.commit_addr !== 32'h2000 + 32'h10 * commits) begin
          n_fail++; $display("FAIL b2b_commit[%0d]: got f=%0d a=%h want f=%0d a=%h", commits, bus.commit_frame, bus.commit_addr, commits % 8, 32'h2000 + 32'h10 * commits);
        end
        bus.commit_ack = 1'b1;
        commits++;
      end
      step();
      cyc++;
      n_cmp++; if (bus.occupancy > 4'd8) begin n_fail++; $display("FAIL b2b_occupancy: got %0d want <=8", bus.occupancy); end
    end
    idle_inputs();
    n_cmp++; if (commits != 10) begin n_fail++; $display("FAIL b2b_timeout: got %0d commits want 10", commits); end
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL b2b_drained: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_ack_flush_alloc();
    int waited;
    do_reset();
    alloc_n(2, 32'h5000);
    bus.done_valid = 1'b1;
    bus.done_frame = 3'd0;
    step();
    bus.done_valid = 1'b0;
    step();
    n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_frame !== 3'd0) begin n_fail++; $display("FAIL combo_wait: got v=%0b f=%0d want v=1 f=0", bus.commit_valid, bus.commit_frame); end
    bus.commit_ack  = 1'b1;
    bus.flush_req   = 1'b1;
    bus.flush_frame = 3'd1;
    bus.alloc_req   = 1'b1;
    bus.alloc_addr  = 32'hBEEF;
    #1;
    n_cmp++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL combo_alloc_rejected: got %0b want 0", bus.alloc_ready); end
    step();
    idle_inputs();
    n_cmp++; if (bus.occupancy !== 4'd0) begin n_fail++; $display("FAIL combo_occupancy: got %0d want 0", bus.occupancy); end
    n_cmp++; if (bus.flush_mask !== 8'h02) begin n_fail++; $display("FAIL combo_flush_mask: got %h want 02", bus.flush_mask); end
    n_cmp++; if (bus.inflight_mask !== 8'h00 || bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL combo_state: got mask=%h v=%0b want 00/0", bus.inflight_mask, bus.commit_valid); end
    n_cmp++; if (bus.alloc_frame !== 3'd1) begin n_fail++; $display("FAIL combo_tail: got %0d want 1", bus.alloc_frame); end
    alloc_n(1, 32'h6000);
    bus.done_valid = 1'b1;
    bus.done_frame = 3'd1;
    step();
    idle_inputs();
    waited = 0;
    while (bus.commit_valid !== 1'b1 && waited < 8) begin step(); waited++; end
    n_cmp++; if (bus.commit_valid !== 1'b1 || bus.commit_frame !== 3'd1 || bus.commit_addr !== 32'h6000) begin
      n_fail++; $display("FAIL combo_head: got v=%0b f=%0d a=%h want v=1 f=1 a=6000", bus.commit_valid, bus.commit_frame, bus.commit_addr);
    end
    bus.commit_ack = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset_mid_commit();
    do_reset();
    alloc_n(4, 32'h7000);
    bus.done_valid = 1'b1;
    bus.done_frame = 3'd0;
    step();
    bus.done_valid = 1'b0;
    step();
    n_cmp++; if (bus.commit_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_wait: got %0b want 1", bus.commit_valid); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_commit_valid: got %0b want 0", bus.commit_valid); end
    n_cmp++; if (bus.inflight_mask !== 8'h00) begin n_fail++; $display("FAIL midrst_inflight: got %h want 00", bus.inflight_mask); end
    n_cmp++; if (bus.alloc_frame !== 3'd0) begin n_fail++; $display("FAIL midrst_alloc_frame: got %0d want 0", bus.alloc_frame); end
    bus.commit_ack = 1'b1;
    step();
    bus.commit_ack = 1'b0;
    n_cmp++; if (bus.occupancy !== 4'd0 || bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stray_ack: got occ=%0d v=%0b want 0/0", bus.occupancy, bus.commit_valid); end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill();
    test_inorder_commit();
    test_flush();
    test_back_to_back();
    test_ack_flush_alloc();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
